// File: rtl/logicnets_seq_pkg.sv
// Shared definitions for the LogicNets layer sequencer.
//   state_t      - sequencer FSM states
//   CFG_SEL_*    - cfg_sel encodings (truth table / connectivity)
//   conn_w/tt_w  - derived widths (connectivity field, truth-table word)
package logicnets_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic CFG_SEL_TT   = 1'b0;
  localparam logic CFG_SEL_CONN = 1'b1;

  // Bits needed to name one input bit of the layer input vector.
  function automatic int conn_w(input int in_bits);
    return $clog2(in_bits);
  endfunction

  // One truth-table word holds an output bit for every FAN_IN-bit address.
  function automatic int tt_w(input int fan_in);
    return 1 << fan_in;
  endfunction

endpackage

// File: rtl/lut_table_mem.sv
// Small distributed memory: one synchronous write port, one asynchronous
// read port. Used for both the truth tables and the connectivity table.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data
module lut_table_mem #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; configuration must survive
  // a reset of the control logic, and a reset port would block mapping
  // onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/logicnets_layer_sequencer.sv
// Time-multiplexed evaluator for one LogicNets layer. An accepted input
// vector is latched, then neurons 0..N_NEURONS-1 are evaluated one per
// cycle through a shared truth-table memory addressed via a connectivity
// table. The assembled output vector is offered on a valid/ready port.
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - input vector handshake, in_vec payload
//   out_valid/out_ready   - output vector handshake, out_vec payload
//   cfg_we/cfg_sel/
//   cfg_addr/cfg_wdata    - runtime load of truth table or connectivity
//   busy                  - high while evaluating or holding an output
//   cfg_err               - one-cycle pulse for a rejected config write
module logicnets_layer_sequencer
  import logicnets_seq_pkg::*;
#(
  parameter int IN_BITS   = 64,
  parameter int N_NEURONS = 32,
  parameter int FAN_IN    = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_BITS-1:0]           in_vec,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_NEURONS-1:0]         out_vec,
  input  logic                         cfg_we,
  input  logic                         cfg_sel,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [63:0]                  cfg_wdata,
  output logic                         busy,
  output logic                         cfg_err
);

  localparam int CONN_W    = conn_w(IN_BITS);
  localparam int TT_W      = tt_w(FAN_IN);
  localparam int CONN_BITS = FAN_IN * CONN_W;
  localparam int IDX_W     = $clog2(N_NEURONS);
  // With a power-of-two neuron count every cfg_addr value is a real neuron.
  localparam bit ALL_ADDR_VALID = ((1 << IDX_W) == N_NEURONS);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IN_BITS-1:0]   vec_q, vec_d;
  logic                 out_valid_q, out_valid_d;
  logic [N_NEURONS-1:0] out_vec_q, out_vec_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 addr_ok;
  logic                 cfg_ok;
  logic                 tt_we, conn_we;
  logic [TT_W-1:0]      tt_rdata;
  logic [CONN_BITS-1:0] conn_rdata;
  logic [FAN_IN-1:0]    tt_addr;
  logic [CONN_W-1:0]    conn_field;
  logic [CONN_W-1:0]    conn_sel;

  // Config writes land only while idle and only for existing neurons.
  assign addr_ok = ALL_ADDR_VALID || (int'(cfg_addr) < N_NEURONS);
  assign cfg_ok  = cfg_we && (state_q == IDLE) && addr_ok;
  assign tt_we   = cfg_ok && (cfg_sel == CFG_SEL_TT);
  assign conn_we = cfg_ok && (cfg_sel == CFG_SEL_CONN);

  lut_table_mem #(
    .DEPTH(N_NEURONS),
    .WIDTH(TT_W)
  ) u_tt_mem (
    .clk  (clk),
    .we   (tt_we),
    .waddr(cfg_addr),
    .wdata(cfg_wdata[TT_W-1:0]),
    .raddr(idx_q),
    .rdata(tt_rdata)
  );

  lut_table_mem #(
    .DEPTH(N_NEURONS),
    .WIDTH(CONN_BITS)
  ) u_conn_mem (
    .clk  (clk),
    .we   (conn_we),
    .waddr(cfg_addr),
    .wdata(cfg_wdata[CONN_BITS-1:0]),
    .raddr(idx_q),
    .rdata(conn_rdata)
  );

  // Gather the current neuron's input bits; an out-of-range connectivity
  // index wraps onto the input vector.
  // NOTE: every always_comb output gets a default before any branch or
  // loop so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    tt_addr    = '0;
    conn_field = '0;
    conn_sel   = '0;
    for (int k = 0; k < FAN_IN; k++) begin
      conn_field = conn_rdata[k*CONN_W +: CONN_W];
      conn_sel   = CONN_W'(int'(conn_field) % IN_BITS);
      tt_addr[k] = vec_q[conn_sel];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    out_valid_d = out_valid_q;
    out_vec_d   = out_vec_q;
    cfg_err_d   = cfg_we && !((state_q == IDLE) && addr_ok);
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d   = in_vec;
          idx_d   = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        out_vec_d[idx_q] = tt_rdata[tt_addr];
        if (idx_q == IDX_W'(N_NEURONS - 1)) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      vec_q       <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vec_q       <= vec_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_logicnets_layer_sequencer.sv
// Self-checking bench for logicnets_layer_sequencer. A golden model of the
// truth tables and connectivity predicts each output vector; predictions
// are queued at accept time and compared when the DUT offers a vector.
// A second instance with 24 neurons exercises out-of-range cfg_addr.
module tb_logicnets_layer_sequencer;

  localparam int IN_BITS   = 64;
  localparam int N_NEURONS = 32;
  localparam int FAN_IN    = 6;
  localparam int CONN_W    = 6;
  localparam int N_ODD     = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_BITS-1:0]   in_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_NEURONS-1:0] out_vec;
  logic                 cfg_we;
  logic                 cfg_sel;
  logic [4:0]           cfg_addr;
  logic [63:0]          cfg_wdata;
  logic                 busy;
  logic                 cfg_err;

  logic                 o_in_ready;
  logic                 o_out_valid;
  logic [N_ODD-1:0]     o_out_vec;
  logic                 o_cfg_we;
  logic [4:0]           o_cfg_addr;
  logic                 o_busy;
  logic                 o_cfg_err;

  always #5 clk = ~clk;

  logicnets_layer_sequencer #(
    .IN_BITS(IN_BITS), .N_NEURONS(N_NEURONS), .FAN_IN(FAN_IN)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .busy(busy), .cfg_err(cfg_err)
  );

  logicnets_layer_sequencer #(
    .IN_BITS(IN_BITS), .N_NEURONS(N_ODD), .FAN_IN(FAN_IN)
  ) dut_odd (
    .clk(clk), .rst(rst),
    .in_valid(1'b0), .in_ready(o_in_ready), .in_vec('0),
    .out_valid(o_out_valid), .out_ready(1'b1), .out_vec(o_out_vec),
    .cfg_we(o_cfg_we), .cfg_sel(1'b0), .cfg_addr(o_cfg_addr),
    .cfg_wdata(64'hFFFF_0000_FFFF_0000), .busy(o_busy), .cfg_err(o_cfg_err)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int accept_cycle = 0;

  logic [N_NEURONS-1:0] sb [$];
  logic [63:0]          tt_m   [N_NEURONS];
  logic [35:0]          conn_m [N_NEURONS];
  logic [63:0]          vec1;
  logic [N_NEURONS-1:0] lookup_obs;

  function automatic logic [N_NEURONS-1:0] model(input logic [IN_BITS-1:0] v);
    logic [N_NEURONS-1:0] r;
    logic [FAN_IN-1:0]    a;
    logic [CONN_W-1:0]    f;
    r = '0;
    for (int n = 0; n < N_NEURONS; n++) begin
      a = '0;
      for (int k = 0; k < FAN_IN; k++) begin
        f    = conn_m[n][k*CONN_W +: CONN_W];
        a[k] = v[f];
      end
      r[n] = tt_m[n][a];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic cfg_write(input logic sel, input int addr, input logic [63:0] data,
                           input string name);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = 5'(addr);
    cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL %s cfg_err: got %b expected 0", name, cfg_err);
    end
    if (sel) conn_m[addr] = data[35:0];
    else     tt_m[addr]   = data;
  endtask

  task automatic accept_vector(input logic [IN_BITS-1:0] v, input string name);
    in_vec   = v;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before accept: got %b expected 1", name, in_ready);
    end
    sb.push_back(model(v));
    accept_cycle = cycle;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_vector(input string name, input int stall,
                               output logic [N_NEURONS-1:0] obs);
    logic [N_NEURONS-1:0] exp;
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: out_valid never rose", name);
      obs = 'x;
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    checks++;
    if (cycle - accept_cycle != N_NEURONS + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, cycle - accept_cycle, N_NEURONS + 1);
    end
    exp = sb.pop_front();
    obs = out_vec;
    checks++;
    if (out_vec !== exp) begin
      errors++;
      $display("FAIL %s out_vec: got %h expected %h", name, out_vec, exp);
    end
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_vec !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s stall %0d: valid=%b vec=%h in_ready=%b expected 1 %h 0",
                 name, i, out_valid, out_vec, in_ready, exp);
      end
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_vec !== exp) begin
      errors++;
      $display("FAIL %s at handshake: valid=%b vec=%h expected 1 %h", name, out_valid, out_vec, exp);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after handshake: in_ready=%b out_valid=%b expected 1 0",
               name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_vec !== '0 ||
        cfg_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_vec=%h cfg_err=%b busy=%b expected 1 0 0 0 0",
               in_ready, out_valid, out_vec, cfg_err, busy);
    end
  endtask

  task automatic init_config();
    logic [35:0] c;
    for (int n = 0; n < N_NEURONS; n++) begin
      cfg_write(1'b0, n, {$urandom, $urandom}, "init_tt");
      for (int k = 0; k < FAN_IN; k++) c[k*CONN_W +: CONN_W] = 6'($urandom_range(0, 63));
      // High junk bits above the connectivity fields must be ignored.
      cfg_write(1'b1, n, {28'($urandom), c}, "init_conn");
    end
  endtask

  task automatic test_lookup();
    logic [N_NEURONS-1:0] obs;
    cfg_write(1'b0, 0, 64'h0000_0000_0000_4000, "lookup_tt");
    cfg_write(1'b1, 0, {28'hABCDEF1, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0}, "lookup_conn");
    vec1 = {$urandom, $urandom};
    vec1[5:0] = 6'b001110;
    accept_vector(vec1, "lookup_a");
    finish_vector("lookup_a", 0, obs);
    lookup_obs = obs;
    checks++;
    if (obs[0] !== 1'b1) begin
      errors++;
      $display("FAIL lookup_a bit0: got %b expected 1", obs[0]);
    end
    accept_vector({vec1[63:6], 6'b001111}, "lookup_b");
    finish_vector("lookup_b", 0, obs);
    checks++;
    if (obs[0] !== 1'b0) begin
      errors++;
      $display("FAIL lookup_b bit0: got %b expected 0", obs[0]);
    end
  endtask

  task automatic test_conn_perm();
    logic [N_NEURONS-1:0] obs;
    logic [63:0] v;
    cfg_write(1'b0, 3, 64'h7FFF_FFFF_FFFF_FFFF, "perm_tt");
    cfg_write(1'b1, 3, {28'h0, 6'd63, 6'd62, 6'd61, 6'd60, 6'd59, 6'd58}, "perm_conn");
    v = {$urandom, $urandom};
    v[63:58] = 6'h3F;
    accept_vector(v, "perm_all_ones");
    finish_vector("perm_all_ones", 0, obs);
    checks++;
    if (obs[3] !== 1'b0) begin
      errors++;
      $display("FAIL perm_all_ones bit3: got %b expected 0", obs[3]);
    end
    for (int b = 0; b < 6; b++) begin
      logic [63:0] w;
      w = v;
      w[58+b] = 1'b0;
      accept_vector(w, "perm_clear");
      finish_vector("perm_clear", 0, obs);
      checks++;
      if (obs[3] !== 1'b1) begin
        errors++;
        $display("FAIL perm_clear bit%0d: got %b expected 1", 58 + b, obs[3]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N_NEURONS-1:0] obs;
    accept_vector({$urandom, $urandom}, "backpressure");
    finish_vector("backpressure", 5, obs);
  endtask

  task automatic test_reject_cfg();
    logic [N_NEURONS-1:0] obs;
    accept_vector(vec1, "reject_eval");
    // A write while evaluating would clobber neuron 0 if it were accepted.
    cfg_we    = 1'b1;
    cfg_sel   = 1'b0;
    cfg_addr  = 5'd0;
    cfg_wdata = 64'h0;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL reject_eval cfg_err: got %b expected 1", cfg_err);
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reject_eval pulse width: got %b expected 0", cfg_err);
    end
    finish_vector("reject_eval", 0, obs);
    checks++;
    if (obs !== lookup_obs) begin
      errors++;
      $display("FAIL reject_eval rerun: got %h expected %h", obs, lookup_obs);
    end
    for (int i = 0; i < 3; i++) begin
      logic [4:0] a;
      logic       exp_err;
      a = (i == 0) ? 5'd24 : (i == 1) ? 5'd31 : 5'd23;
      exp_err = (i != 2);
      o_cfg_addr = a;
      o_cfg_we   = 1'b1;
      tick();
      o_cfg_we = 1'b0;
      checks++;
      if (o_cfg_err !== exp_err) begin
        errors++;
        $display("FAIL reject_addr %0d cfg_err: got %b expected %b", a, o_cfg_err, exp_err);
      end
      tick();
      checks++;
      if (o_cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL reject_addr %0d pulse width: got %b expected 0", a, o_cfg_err);
      end
    end
  endtask

  task automatic test_cfg_with_accept();
    logic [N_NEURONS-1:0] obs;
    cfg_we    = 1'b1;
    cfg_sel   = 1'b0;
    cfg_addr  = 5'd0;
    cfg_wdata = ~64'h0000_0000_0000_4000;
    tt_m[0]   = cfg_wdata;
    accept_vector(vec1, "cfg_with_accept");
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_with_accept cfg_err: got %b expected 0", cfg_err);
    end
    finish_vector("cfg_with_accept", 0, obs);
    checks++;
    if (obs[0] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_with_accept bit0: got %b expected 0", obs[0]);
    end
    cfg_write(1'b0, 0, 64'h0000_0000_0000_4000, "restore_tt");
  endtask

  task automatic test_reset_mid_eval();
    logic [N_NEURONS-1:0] obs;
    accept_vector(vec1, "reset_mid");
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid state: out_valid=%b in_ready=%b busy=%b expected 0 1 0",
               out_valid, in_ready, busy);
    end
    accept_vector(vec1, "reset_mid_rerun");
    finish_vector("reset_mid_rerun", 0, obs);
    checks++;
    if (obs !== lookup_obs) begin
      errors++;
      $display("FAIL reset_mid_rerun retained: got %h expected %h", obs, lookup_obs);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vecs [4];
    logic [N_NEURONS-1:0] exp;
    int cyc, accepts, outs, last;
    for (int i = 0; i < 4; i++) vecs[i] = {$urandom, $urandom};
    cyc = 0;
    accepts = 0;
    outs = 0;
    last = 0;
    in_vec    = vecs[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (outs < 4 && cyc < 400) begin
      if (in_valid && in_ready === 1'b1) begin
        sb.push_back(model(in_vec));
        if (accepts > 0) begin
          checks++;
          if (cyc - last != N_NEURONS + 2) begin
            errors++;
            $display("FAIL b2b spacing: got %0d expected %0d", cyc - last, N_NEURONS + 2);
          end
        end
        last = cyc;
        accepts++;
      end
      if (out_valid === 1'b1) begin
        exp = sb.pop_front();
        checks++;
        if (out_vec !== exp) begin
          errors++;
          $display("FAIL b2b out_vec %0d: got %h expected %h", outs, out_vec, exp);
        end
        outs++;
      end
      tick();
      cyc++;
      if (accepts >= 4) in_valid = 1'b0;
      else              in_vec   = vecs[accepts];
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (outs != 4) begin
      errors++;
      $display("FAIL b2b timeout: got %0d outputs expected 4", outs);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_vec     = '0;
    out_ready  = 1'b0;
    cfg_we     = 1'b0;
    cfg_sel    = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    o_cfg_we   = 1'b0;
    o_cfg_addr = '0;
    test_reset();
    init_config();
    test_lookup();
    test_conn_perm();
    test_backpressure();
    test_reject_cfg();
    test_cfg_with_accept();
    test_reset_mid_eval();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
